// File: rtl/cmem_dbuf.sv
// Double-buffered coefficient memory: loads fill the shadow bank, reads use the active bank.
// Optional CMEM_PARITY_EN adds a per-word even-parity bit and a perr output.
module cmem_dbuf #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int NCH    = 2,
  parameter int ADDR_W = 6,
  parameter int CH_W   = 1
) (
  input  logic                     clk2,
  input  logic                     rst,
  input  logic                     cload,
  input  logic [CH_W-1:0]          cch,
  input  logic [ADDR_W-1:0]        caddr,
  input  logic signed [WIDTH-1:0]  cin,
  output logic                     lerr,
  input  logic                     swap_req,
  output logic                     swap_done,
  output logic                     abank,
  input  logic                     ren,
  input  logic [CH_W-1:0]          rch,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [WIDTH-1:0]  cout,
`ifdef CMEM_PARITY_EN
  output logic                     perr,
`endif
  output logic                     cvalid
);

  localparam int NWORDS = 2 * NCH * DEPTH;
  localparam int IDX_W  = $clog2(NWORDS);
`ifdef CMEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {StIdle, StPend} state_e;

  state_e          state_q, state_d;
  logic            commit;
  logic            load_ok, rd_ok;
  logic [MW-1:0]   wdata, rd_word;
  logic [MW-1:0]   mem [NWORDS];

  // Flat word index: banks outermost, then channels, then addresses.
  function automatic logic [IDX_W-1:0] widx(input logic bank, input logic [CH_W-1:0] ch,
                                            input logic [ADDR_W-1:0] addr);
    return IDX_W'((32'(bank) * NCH + 32'(ch)) * DEPTH + 32'(addr));
  endfunction

  // The extra leading zero keeps the range compares meaningful for any parameter set.
  assign load_ok = cload && ({1'b0, cch} < (CH_W + 1)'(NCH))
                 && ({1'b0, caddr} < (ADDR_W + 1)'(DEPTH)) && (state_q == StIdle);
  assign rd_ok   = ({1'b0, rch} < (CH_W + 1)'(NCH)) && ({1'b0, raddr} < (ADDR_W + 1)'(DEPTH));

`ifdef CMEM_PARITY_EN
  assign wdata = {^cin, cin};
`else
  assign wdata = cin;
`endif

  assign rd_word = mem[widx(abank, rch, raddr)];

  // Bank flips only on an idle read cycle so a burst never straddles two banks.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: if (swap_req) state_d = StPend;
      StPend: begin
        if (!ren) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q   <= StIdle;
      abank     <= 1'b0;
      swap_done <= 1'b0;
      lerr      <= 1'b0;
      cout      <= '0;
      cvalid    <= 1'b0;
`ifdef CMEM_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      abank     <= abank ^ commit;
      swap_done <= commit;
      lerr      <= cload && !load_ok;
      cvalid    <= ren;
      if (ren) cout <= rd_ok ? rd_word[WIDTH-1:0] : '0;
`ifdef CMEM_PARITY_EN
      perr      <= ren && rd_ok && (^rd_word);
`endif
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk2) begin
    if (load_ok && !rst) mem[widx(!abank, cch, caddr)] <= wdata;
  end

endmodule

// File: doc/cmem_dbuf.md
CMEM_DBUF -- requirements
Module: cmem_dbuf

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, meaning signed coefficient width (Q1.15 at default).
REQ-002 The block SHALL provide parameter DEPTH, default 64, meaning coefficients per channel; DEPTH need not be a power of two.
REQ-003 The block SHALL provide parameter NCH, default 2, meaning number of independent coefficient channels.
REQ-004 The block SHALL provide parameter ADDR_W, default 6, meaning coefficient address width, with ADDR_W >= clog2(DEPTH).
REQ-005 The block SHALL provide parameter CH_W, default 1, meaning channel select width, with CH_W >= max(1, clog2(NCH)).
REQ-006 The block SHALL have port clk2  input  1  single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 The block SHALL have port cload  input  1  load strobe, one coefficient per cycle.
REQ-009 The block SHALL have port cch  input  CH_W  load channel.
REQ-010 The block SHALL have port caddr  input  ADDR_W  load address.
REQ-011 The block SHALL have port cin  input  signed WIDTH  load data.
REQ-012 The block SHALL have port lerr  output  1  one-cycle pulse on a rejected load.
REQ-013 The block SHALL have port swap_req  input  1  request to swap the shadow and active banks.
REQ-014 The block SHALL have port swap_done  output  1  one-cycle pulse when a swap is committed.
REQ-015 The block SHALL have port abank  output  1  index of the active bank.
REQ-016 The block SHALL have port ren  input  1  read strobe.
REQ-017 The block SHALL have port rch  input  CH_W  read channel.
REQ-018 The block SHALL have port raddr  input  ADDR_W  read address.
REQ-019 The block SHALL have port cout  output  signed WIDTH  registered read data.
REQ-020 The block SHALL have port cvalid  output  1  high in the cycle cout carries valid read data.

Function
REQ-021 Storage SHALL consist of 2 banks x NCH channels x DEPTH words; loads write only the shadow bank (!abank), and reads access only the active bank (abank).
REQ-022 A load SHALL be accepted when cload=1, cch<NCH, caddr<DEPTH and no swap is pending; the word is written at the clock edge.
REQ-023 A load with cch>=NCH, caddr>=DEPTH, or while a swap is pending SHALL leave memory unchanged and pulse lerr in the following cycle.
REQ-024 Read latency SHALL be one cycle: ren=1 at edge N presents mem[abank][rch][raddr] on cout with cvalid=1 after edge N+1.
REQ-025 When ren=0, cout SHALL hold its last value and cvalid SHALL be 0.
REQ-026 A read with rch>=NCH or raddr>=DEPTH SHALL return cout=0 with cvalid=1.
REQ-027 The swap FSM SHALL have states IDLE and PEND; swap_req=1 in IDLE moves the FSM to PEND.
REQ-028 In PEND, abank SHALL toggle at the first edge where ren=0, swap_done SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-029 swap_req received in PEND SHALL be absorbed, producing no second swap.
REQ-030 A swap SHALL never change bank during a read burst; every cycle with ren=1 reads one consistent bank.
REQ-031 If swap_req=1 and ren=0 in the same IDLE cycle, the swap SHALL commit at the next edge (minimum 2-edge swap latency).
REQ-032 A load and a read in the same cycle SHALL be independent, because they target different banks.

Reset
REQ-033 When rst=1 at an edge: cout=0, cvalid=0, lerr=0, swap_done=0, abank=0, and the FSM is IDLE.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 A reset while in PEND SHALL cancel the pending swap.

Configuration
REQ-036 With CMEM_PARITY_EN defined, each word SHALL store an even-parity bit, and an output perr SHALL be high alongside cvalid when the read word fails its parity check; out-of-range reads SHALL give perr=0.
REQ-037 Without CMEM_PARITY_EN, no parity storage and no perr port SHALL exist.

Verification
REQ-038 Bench: load 64 random words to ch0 and 64 to ch1 (shadow); swap_req with ren=0 -> swap_done pulses 2 edges later, abank=1; reads of all 128 entries match the loaded values with 1-cycle latency.
REQ-039 Bench: swap_req at the start of a 64-read burst -> abank unchanged until the cycle after ren falls, and all 64 reads come from the old bank.
REQ-040 Bench: cload with caddr=64, with cch=2 (NCH=2), and during PEND -> lerr pulses each time and the subsequent readback shows no change.
REQ-041 Bench: ren with raddr=70 -> cout=0 and cvalid=1; ren=0 -> cvalid=0 and cout holds.
REQ-042 Bench: swap_req, then rst asserted while ren=1 -> abank=0, no swap_done, and all outputs zero.
REQ-043 Bench (CMEM_PARITY_EN): force-flip one stored bit via hierarchical deposit, then read it -> perr=1 with cvalid; other addresses give perr=0.
